key_expansion_seq: RTL and testbench
====================================

// Module: key_expansion_seq
// PURPOSE
//  Iterative AES key schedule for AES-128, AES-192 and AES-256, selected by parameter.
//  Computes one 32-bit schedule word per clock using one shared 4-byte Sbox group.
//  Stores all round keys; the round datapath reads any round key by index.
//  Successor to the fully unrolled 128-bit schedule; cuts Sbox count from 40 to 4.
// PARAMETERS
//  KEY_BITS  128  cipher key length; legal values 128, 192, 256 (elaboration error otherwise)
//  Derived: NK=KEY_BITS/32 (4/6/8); NR=NK+6 (10/12/14); NW=4*(NR+1) words (44/52/60)
// PORTS
//  clk        in   1         clock; all state changes on rising edge
//  rst_n      in   1         synchronous, active-low reset
//  start      in   1         request expansion of key_in; sampled only in IDLE
//  key_in     in   KEY_BITS  cipher key; word w0 in MSBs
//  busy       out  1         expansion in progress
//  done       out  1         one-cycle pulse: schedule complete
//  key_valid  out  1         level: stored schedule matches last accepted key
//  rd_round   in   4         round-key index, 0..NR
//  rd_key     out  128       {w[4r],w[4r+1],w[4r+2],w[4r+3]} for r=rd_round; combinational
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; busy=0, done=0, key_valid=0; rcon=8'h01; kc=0.
//   Word storage is not cleared (see CONFIGURATION).
//  States: IDLE -> EXPAND -> IDLE.
//  IDLE: on start=1 at edge E0: w[0..NK-1] <= key_in, i <= NK, kc <= 0, rcon <= 8'h01,
//   busy <= 1, key_valid <= 0, state <= EXPAND. start=0: hold.
//  EXPAND: each edge writes w[i] = w[i-NK] ^ T, then i <= i+1, kc <= (kc==NK-1) ? 0 : kc+1:
//   kc==0            : T = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon <= xtime(rcon)
//   NK==8 && kc==4   : T = SubWord(w[i-1])  (no rotate, no rcon)
//   otherwise        : T = w[i-1]
//   xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00)
//   RotWord({a,b,c,d}) = {b,c,d,a}; SubWord applies Sbox to each byte.
//  Last write (i==NW-1) at edge E(NW-NK), i.e. 40/46/52 edges after E0:
//   busy <= 0, done <= 1, key_valid <= 1, state <= IDLE.
//  done is high for exactly the cycle after that edge, then cleared.
//  Latency: start edge to done visible = NW-NK+1 cycles (41/47/53).
//  start while busy: ignored; no restart, no queueing.
//  start in the cycle done is high (state IDLE): accepted; key_valid drops next edge.
//  rd_key: reads storage at any time; valid only when key_valid=1.
//   During EXPAND it returns partial contents.
//   rd_round > NR: rd_key = 128'h0.
//  Reset mid-EXPAND: IDLE next edge; busy=0, done=0, key_valid=0; partial words discarded.
//  key_in need only be stable in the start cycle; it is captured at E0.
// CONFIGURATION
//  KEYEXP_ZEROIZE_EN defined:
//   - adds input port zeroize (1 bit);
//   - zeroize=1 at an edge clears every w[] to 0 in that edge and forces IDLE,
//     busy=0, done=0, key_valid=0;
//   - zeroize has priority over start and EXPAND; reset also clears w[].
//  KEYEXP_ZEROIZE_EN undefined:
//   - no zeroize port; storage is never cleared; reset affects control state only.
// TESTING
//  T1 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle
//     -> done exactly 41 cycles later; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6;
//        rd_round=0 gives key_in.
//  T2 KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
//     -> done after 47 cycles; rd_round=12 gives e98ba06f448c773c8ecc720401002202.
//  T3 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
//     -> done after 53 cycles; rd_round=14 gives fe4890d1e6188d0b046df344706c631e.
//  T4 128-bit; second start with a different key at cycle 10 of expansion
//     -> ignored; T1 round-10 result unchanged; exactly one done pulse.
//  T5 128-bit; rst_n=0 at cycle 20 for 1 cycle, then start with T1 key
//     -> busy/key_valid low after reset edge; fresh run gives T1 result at +41.
//  T6 KEYEXP_ZEROIZE_EN; after T1, zeroize=1 for 1 cycle
//     -> key_valid=0; rd_key=0 for rounds 0..10; rd_round=11 always 0.

Source files
------------

// File: rtl/key_expansion_seq.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock, 4 Sboxes.
// Optional KEYEXP_ZEROIZE_EN adds a zeroize port that wipes stored round keys.
module key_expansion_seq #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef KEYEXP_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                key_valid,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK6    = 6'(NK);
  localparam logic [5:0] I_LAST = 6'(NW - 1);
  localparam logic [2:0] KC_LST = 3'(NK - 1);
  localparam logic [3:0] NR4    = 4'(NR);
  localparam bit         IS256  = (NK == 8);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad
    $error("key_expansion_seq: KEY_BITS must be 128, 192 or 256");
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Sbox = affine(x^254); x^254 is the field inverse with 0 -> 0
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    logic [7:0] b;
    r = 8'h01;
    s = x;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [0:0]  state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  kc_q, kc_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        kv_q, kv_d;
  logic [31:0] w_q [NW];

  logic        zap;
  logic        clr;
`ifdef KEYEXP_ZEROIZE_EN
  assign zap = zeroize;
  assign clr = zeroize | ~rst_n;
`else
  assign zap = 1'b0;
  assign clr = 1'b0;
`endif

  logic        load;
  logic        wr_en;
  logic [31:0] prev_w;
  logic [31:0] old_w;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t_w;
  logic [31:0] new_w;
  logic        is_rc;
  logic        is_sub;

  assign load  = rst_n & ~zap & (state_q == IDLE) & start;
  assign wr_en = rst_n & ~zap & (state_q == EXPAND);

  assign prev_w = w_q[i_q - 6'd1];
  assign old_w  = w_q[i_q - NK6];
  assign is_rc  = (kc_q == 3'd0);
  assign is_sub = IS256 && (kc_q == 3'd4);

  // RotWord only on the rcon step; the shared Sbox group serves both cases
  assign sub_in = is_rc ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  // Four Sbox lanes shared by every schedule step
  always_comb begin
    sub_out = '0;
    for (int b = 0; b < 4; b++) begin
      sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
    end
  end

  // Select the transform applied to the previous word
  always_comb begin
    t_w = prev_w;
    unique case (1'b1)
      is_rc:           t_w = sub_out ^ {rcon_q, 24'h0};
      is_sub:          t_w = sub_out;
      !is_rc&&!is_sub: t_w = prev_w;
      default:         t_w = prev_w;
    endcase
  end

  assign new_w = old_w ^ t_w;

  // Next-state logic for the IDLE/EXPAND controller
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    kc_d    = kc_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = NK6;
          kc_d    = 3'd0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          kv_d    = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        i_d  = i_q + 6'd1;
        kc_d = (kc_q == KC_LST) ? 3'd0 : kc_q + 3'd1;
        if (is_rc) rcon_d = xtime(rcon_q);
        if (i_q == I_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (zap) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      kv_d    = 1'b0;
    end
  end

  // Controller registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      kc_q    <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      kc_q    <= kc_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
    end
  end

  // Word storage: key load, one schedule word per step, optional wipe
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NK; k++) begin
        w_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
      end
    end else if (wr_en) begin
      w_q[i_q] <= new_w;
    end
  end

  logic [5:0] base;
  assign base = {rd_round, 2'b00};

  // Round-key read port; indices past the last round read as zero
  always_comb begin
    rd_key = '0;
    if (rd_round <= NR4) begin
      rd_key = {w_q[base], w_q[base + 6'd1],
                w_q[base + 6'd2], w_q[base + 6'd3]};
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq at all three key sizes.
// Reference schedule built from a table-driven FIPS-197 model.
`timescale 1ns/1ns
module tb_key_expansion_seq;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef struct {
    logic [0:59][31:0] w;
    int                dc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   fin [3];

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] subw(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = SBOX[2047 - 8*int'(x[8*b +: 8]) -: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input int n);
    case (n)
      0: return 8'h01; 1: return 8'h02; 2: return 8'h04; 3: return 8'h08;
      4: return 8'h10; 5: return 8'h20; 6: return 8'h40; 7: return 8'h80;
      8: return 8'h1b; default: return 8'h36;
    endcase
  endfunction

  // key is left-aligned in 256 bits
  function automatic logic [0:59][31:0] expand(input int nk, input logic [255:0] key);
    logic [0:59][31:0] w;
    logic [31:0] t;
    int nw;
    nw = 4 * (nk + 7);
    w = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon(i/nk - 1), 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_sz
    localparam int KB = 128 + 64*g;
    localparam int NK = KB / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [255:0] KATK =
      (g == 0) ? {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0} :
      (g == 1) ? {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0} :
                 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] KATR =
      (g == 0) ? 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 :
      (g == 1) ? 128'he98ba06f448c773c8ecc720401002202 :
                 128'hfe4890d1e6188d0b046df344706c631e;

    logic          rst_n;
    logic          start;
    logic [KB-1:0] key;
    logic          busy;
    logic          done;
    logic          kv;
    logic [3:0]    rd_round;
    logic [127:0]  rd_key;
`ifdef KEYEXP_ZEROIZE_EN
    logic          zeroize;
`endif
    exp_t          q[$];

    key_expansion_seq #(.KEY_BITS(KB)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef KEYEXP_ZEROIZE_EN
      .zeroize   (zeroize),
`endif
      .start     (start),
      .key_in    (key),
      .busy      (busy),
      .done      (done),
      .key_valid (kv),
      .rd_round  (rd_round),
      .rd_key    (rd_key)
    );

    // Monitor: every done pulse must match one expected schedule
    always @(negedge clk) begin
      exp_t e;
      logic [127:0] want;
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk($sformatf("k%0d_done_unexpected", KB), 128'(done), 128'(0));
        end else begin
          e = q.pop_front();
          chk($sformatf("k%0d_done_cycle", KB), 128'(cyc), 128'(e.dc));
          chk($sformatf("k%0d_kv_at_done", KB), 128'(kv), 128'(1));
          chk($sformatf("k%0d_busy_at_done", KB), 128'(busy), 128'(0));
          for (int r = 0; r <= NR + 1; r++) begin
            rd_round = 4'(r);
            #1;
            want = (r <= NR) ? {e.w[4*r], e.w[4*r+1], e.w[4*r+2], e.w[4*r+3]} : '0;
            chk($sformatf("k%0d_round%0d", KB, r), rd_key, want);
          end
        end
      end
    end

    function automatic logic [KB-1:0] rkey();
      logic [KB-1:0] k;
      for (int j = 0; j < NK; j++) k[32*j +: 32] = $urandom;
      return k;
    endfunction

    // Called at a falling edge; the next rising edge is the start edge
    task automatic go(input logic [KB-1:0] k);
      exp_t e;
      key   = k;
      start = 1'b1;
      e.w   = expand(NK, 256'(k) << (256 - KB));
      e.dc  = cyc + 1 + NW - NK;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      key   = rkey();
      chk($sformatf("k%0d_busy_after_start", KB), 128'(busy), 128'(1));
      chk($sformatf("k%0d_kv_after_start", KB), 128'(kv), 128'(0));
    endtask

    task automatic wait_done();
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done !== 1'b1 && n < 200);
      if (done !== 1'b1)
        chk($sformatf("k%0d_done_timeout", KB), 128'(done), 128'(1));
    endtask

    initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      key      = '0;
      rd_round = '0;
`ifdef KEYEXP_ZEROIZE_EN
      zeroize  = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk($sformatf("k%0d_rst_busy", KB), 128'(busy), 128'(0));
      chk($sformatf("k%0d_rst_done", KB), 128'(done), 128'(0));
      chk($sformatf("k%0d_rst_kv", KB), 128'(kv), 128'(0));

      // Known-answer run
      @(negedge clk);
      go(KATK[255 -: KB]);
      wait_done();
      @(negedge clk);
      rd_round = 4'(NR);
      #1 chk($sformatf("k%0d_kat_last", KB), rd_key, KATR);
      rd_round = 4'd0;
      #1 chk($sformatf("k%0d_kat_r0", KB), rd_key, KATK[255 -: 128]);

      // Start while busy is ignored
      go(rkey());
      repeat (10) @(negedge clk);
      key   = rkey();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Start in the done cycle is accepted
      go(rkey());
      wait_done();

      // Reset in the middle of an expansion
      go(rkey());
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      chk($sformatf("k%0d_midrst_busy", KB), 128'(busy), 128'(0));
      chk($sformatf("k%0d_midrst_kv", KB), 128'(kv), 128'(0));
      chk($sformatf("k%0d_midrst_done", KB), 128'(done), 128'(0));
      go(KATK[255 -: KB]);
      wait_done();

      // Random keys with random idle gaps
      for (int it = 0; it < 3; it++) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        go(rkey());
        wait_done();
      end

`ifdef KEYEXP_ZEROIZE_EN
      @(negedge clk);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      chk($sformatf("k%0d_zero_kv", KB), 128'(kv), 128'(0));
      for (int r = 0; r < 16; r++) begin
        rd_round = 4'(r);
        #1 chk($sformatf("k%0d_zero_r%0d", KB, r), rd_key, 128'h0);
      end
`endif

      repeat (3) @(negedge clk);
      chk($sformatf("k%0d_queue_empty", KB), 128'(q.size()), 128'(0));
      fin[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(fin[0] && fin[1] && fin[2]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(fin[0] && fin[1] && fin[2]))
      chk("global_timeout", 128'(0), 128'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
